lcm_output_arbiter: RTL and testbench
=====================================

# lcm_output_arbiter

Output arbiter for the local control management datapath. It merges three packet sources onto the single 134-bit port towards the IO port:
- frame encapsulation (FEM), a stream with no backpressure;
- frame decapsulation (FDM), a stream with no backpressure;
- config state management (LCM), via req/ack.

FEM and FDM each get an internal packet FIFO with commit/rollback so only whole packets are arbitrated. Arbitration is round-robin and packet-atomic, gated by the downstream FIFO fill level.

## Interface
Parameters:
- FIFO_AW, 6 — address width of each per-source FIFO (64 × 134-bit words).
- USEDW_TH, 7'd48 — a new packet starts only when iv_fifo_usedw ≤ this value.

Ports:
- i_clk  in  1  — single clock.
- i_rst  in  1  — asynchronous, active-high reset.
- iv_data_fem  in  134  — FEM word; [133:132] = 01 head, 11 middle, 10 tail.
- i_data_fem_wr  in  1  — FEM word valid.
- iv_data_fdm  in  134  — FDM word, same format.
- i_data_fdm_wr  in  1  — FDM word valid.
- i_data_lcm_req  in  1  — LCM has a complete packet ready; held until ack.
- o_data_lcm_ack  out  1  — one-cycle grant pulse to LCM.
- iv_data_lcm  in  134  — LCM words, contiguous from the cycle after ack up to and including the tail.
- iv_fifo_usedw  in  7  — downstream FIFO fill level.
- ov_data  out  134  — merged output word.
- o_data_wr  out  1  — output word valid.
- ov_fem_drop_cnt  out  16  — FEM packets dropped; saturates at 16'hFFFF.
- ov_fdm_drop_cnt  out  16  — FDM packets dropped; saturates at 16'hFFFF.

## Operation
**Per-source FIFO write side (FEM and FDM independently)**
- Pointers: wptr, cptr (commit), rptr.
- pkt_cnt is the number of committed packets not yet read.
- The FIFO is full when wptr+1 == rptr (mod 2^FIFO_AW).
- Head word with wr: cptr := wptr, the word is written, in_pkt := 1.
- Middle word while in_pkt: written.
- Tail word while in_pkt: written, cptr := wptr+1, pkt_cnt increments, in_pkt := 0.
- Any word arriving when the FIFO is full:
  - wptr := cptr, the drop counter increments once, and drop mode is entered;
  - all words through the next tail, inclusive, are discarded.
- Head arriving while in_pkt (tail was missing):
  - wptr := cptr, the drop counter increments;
  - the new head is then written normally.
- Middle or tail word with neither in_pkt nor drop mode: discarded silently, not counted.
- A head arriving while in drop mode ends drop mode and is written as a normal head.

**Arbiter FSM: IDLE, FEM_RD, FDM_RD, LCM_RD**
- In IDLE, the arbiter evaluates when iv_fifo_usedw ≤ USEDW_TH.
- Eligible sources:
  - FEM when its pkt_cnt ≠ 0;
  - FDM when its pkt_cnt ≠ 0;
  - LCM when i_data_lcm_req = 1.
- Round-robin order is FEM → FDM → LCM. The search starts at the source after the last granted one; after reset, search starts at FEM.
- FEM_RD / FDM_RD:
  - the arbiter reads one word per cycle from rptr;
  - when the tail word is read, pkt_cnt decrements and the FSM returns to IDLE.
- LCM_RD:
  - entered with o_data_lcm_ack = 1 for that single cycle;
  - the arbiter registers iv_data_lcm each following cycle;
  - after the tail is captured, the FSM returns to IDLE.
- If pkt_cnt increments (tail write) and decrements (tail read) in the same cycle, it stays net unchanged.
- Once a packet starts, it runs to its tail regardless of iv_fifo_usedw.

**Reset, asynchronous, any time**
- All pointers, pkt_cnt, in_pkt, drop mode and the RR pointer are cleared; the FSM goes to IDLE.
- Partially written or partially sent packets are lost.
- Reset values: ov_data = 0, o_data_wr = 0, o_data_lcm_ack = 0, both drop counters = 0.

## Timing
- FIFO memory read is registered: the first output word appears 2 cycles after the IDLE grant cycle.
- Words within a packet are output back-to-back, one per cycle.
- LCM path:
  - ack is asserted at cycle T;
  - LCM head is driven at T+1;
  - ov_data/o_data_wr show the head at T+2;
  - all following words keep the same 1-cycle offset.
- Between packets:
  - the FSM re-enters IDLE on the cycle after the tail is issued;
  - this gives a minimum 1-cycle o_data_wr gap between back-to-back packets.
- FIFO write: a packet is eligible for grant in the cycle after its tail is written.
- Drop counters update 1 cycle after the triggering word.

## Test plan
- **Single FEM packet.** FEM writes a 4-word packet (01, 11, 11, 10) while iv_fifo_usedw = 0. Required: o_data_wr high for exactly 4 cycles, words identical and in order, first word 3 cycles after the FEM tail write.
- **Round-robin across all three sources.** FEM and FDM each hold 2 committed packets and LCM req is held. Required grant order FEM, FDM, LCM, FEM, FDM. Exactly one ack pulse, and the LCM head is output 2 cycles after ack.
- **Overflow rollback.** FEM writes a 70-word packet into the empty 64-word FIFO with no grants (usedw = 100). Required: ov_fem_drop_cnt = 1, pkt_cnt stays 0; a following 3-word packet is output intact once usedw drops to 0.
- **Missing tail.** FDM sends head, middle, then a new head, middle, tail. Required: ov_fdm_drop_cnt = 1 and only the second 3-word packet appears on the output.
- **Backpressure gating.** Set iv_fifo_usedw = 49 with packets pending. Required: no grant. At usedw = 48, a grant occurs; raising usedw to 60 mid-packet does not interrupt the packet.
- **Reset mid-packet.** Assert i_rst during word 2 of an LCM transfer. Required: all outputs go to 0 immediately; after release, o_data_wr stays 0 until new packets arrive.

Source files
------------

// File: rtl/lcm_output_arbiter.sv
// Output arbiter merging FEM, FDM (via per-source packet FIFOs with commit/rollback)
// and LCM (req/ack) onto a single 134-bit port, packet-atomic round-robin.
module lcm_output_arbiter #(
  parameter int unsigned FIFO_AW  = 6,
  parameter logic [6:0]  USEDW_TH = 7'd48
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [133:0] iv_data_fem,
  input  logic         i_data_fem_wr,
  input  logic [133:0] iv_data_fdm,
  input  logic         i_data_fdm_wr,
  input  logic         i_data_lcm_req,
  output logic         o_data_lcm_ack,
  input  logic [133:0] iv_data_lcm,
  input  logic [6:0]   iv_fifo_usedw,
  output logic [133:0] ov_data,
  output logic         o_data_wr,
  output logic [15:0]  ov_fem_drop_cnt,
  output logic [15:0]  ov_fdm_drop_cnt
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW-1:0] PtrOne = 1;
  localparam logic [1:0] TypHead = 2'b01;
  localparam logic [1:0] TypMid  = 2'b11;
  localparam logic [1:0] TypTail = 2'b10;

  typedef enum logic [1:0] {StIdle, StFemRd, StFdmRd, StLcmRd} state_e;

  logic [133:0] src_data [2];
  logic [1:0]   src_wr;
  logic [133:0] rd_word  [2];
  logic [15:0]  drop_cnt [2];
  logic [1:0]   pkt_avail;
  logic [1:0]   peek_tail;
  logic [1:0]   rd_en;
  logic [1:0]   pkt_dec;

  assign src_data[0] = iv_data_fem;
  assign src_data[1] = iv_data_fdm;
  assign src_wr      = {i_data_fdm_wr, i_data_fem_wr};

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [133:0]       mem [Depth];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] cptr_q, cptr_d;
    logic [FIFO_AW-1:0] rptr_q;
    logic [FIFO_AW-1:0] pkt_cnt_q;
    logic [15:0]        drop_cnt_q;
    logic               in_pkt_q, in_pkt_d;
    logic               drop_q, drop_d;
    logic               drop_inc, pkt_inc, wr_en, full;
    logic [FIFO_AW-1:0] waddr;
    logic [1:0]         typ;

    assign typ  = src_data[s][133:132];
    assign full = (wptr_q + PtrOne) == rptr_q;

    always_comb begin
      wr_en    = 1'b0;
      waddr    = wptr_q;
      wptr_d   = wptr_q;
      cptr_d   = cptr_q;
      in_pkt_d = in_pkt_q;
      drop_d   = drop_q;
      drop_inc = 1'b0;
      pkt_inc  = 1'b0;
      if (src_wr[s]) begin
        if (drop_q && typ != TypHead) begin
          if (typ == TypTail) drop_d = 1'b0;
        end else if (full) begin
          // Roll back the partial packet and discard up to its tail.
          wptr_d   = cptr_q;
          drop_inc = 1'b1;
          drop_d   = (typ != TypTail);
          in_pkt_d = 1'b0;
        end else if (typ == TypHead) begin
          drop_inc = in_pkt_q;
          waddr    = in_pkt_q ? cptr_q : wptr_q;
          wr_en    = 1'b1;
          cptr_d   = waddr;
          wptr_d   = waddr + PtrOne;
          in_pkt_d = 1'b1;
          drop_d   = 1'b0;
        end else if (in_pkt_q && typ == TypMid) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + PtrOne;
        end else if (in_pkt_q && typ == TypTail) begin
          wr_en    = 1'b1;
          wptr_d   = wptr_q + PtrOne;
          cptr_d   = wptr_q + PtrOne;
          in_pkt_d = 1'b0;
          pkt_inc  = 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (wr_en) mem[waddr] <= src_data[s];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        wptr_q     <= '0;
        cptr_q     <= '0;
        rptr_q     <= '0;
        pkt_cnt_q  <= '0;
        drop_cnt_q <= '0;
        in_pkt_q   <= 1'b0;
        drop_q     <= 1'b0;
      end else begin
        wptr_q   <= wptr_d;
        cptr_q   <= cptr_d;
        in_pkt_q <= in_pkt_d;
        drop_q   <= drop_d;
        if (rd_en[s]) rptr_q <= rptr_q + PtrOne;
        case ({pkt_inc, pkt_dec[s]})
          2'b10:   pkt_cnt_q <= pkt_cnt_q + PtrOne;
          2'b01:   pkt_cnt_q <= pkt_cnt_q - PtrOne;
          default: pkt_cnt_q <= pkt_cnt_q;
        endcase
        if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end

    assign pkt_avail[s] = (pkt_cnt_q != '0);
    assign peek_tail[s] = (mem[rptr_q][133:132] == TypTail);
    assign rd_word[s]   = mem[rptr_q];
    assign drop_cnt[s]  = drop_cnt_q;
  end

  assign ov_fem_drop_cnt = drop_cnt[0];
  assign ov_fdm_drop_cnt = drop_cnt[1];

  state_e       state_q, state_d;
  logic [1:0]   start_q, start_d;
  logic [1:0]   cand0, cand1, cand2, grant_sel;
  logic [2:0]   elig;
  logic         grant_found;
  logic         ack_q, ack_d;
  logic         lcm_cap;
  logic         wr_q;
  logic [133:0] data_q;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign elig  = {i_data_lcm_req, pkt_avail};
  assign cand0 = start_q;
  assign cand1 = next_src(cand0);
  assign cand2 = next_src(cand1);

  always_comb begin
    grant_found = 1'b1;
    grant_sel   = cand0;
    if (elig[cand0])      grant_sel = cand0;
    else if (elig[cand1]) grant_sel = cand1;
    else if (elig[cand2]) grant_sel = cand2;
    else                  grant_found = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    rd_en   = 2'b00;
    pkt_dec = 2'b00;
    ack_d   = 1'b0;
    lcm_cap = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iv_fifo_usedw <= USEDW_TH && grant_found) begin
          start_d = next_src(grant_sel);
          unique case (grant_sel)
            2'd0:    state_d = StFemRd;
            2'd1:    state_d = StFdmRd;
            default: begin
              state_d = StLcmRd;
              ack_d   = 1'b1;
            end
          endcase
        end
      end
      StFemRd: begin
        rd_en[0] = 1'b1;
        if (peek_tail[0]) begin
          pkt_dec[0] = 1'b1;
          state_d    = StIdle;
        end
      end
      StFdmRd: begin
        rd_en[1] = 1'b1;
        if (peek_tail[1]) begin
          pkt_dec[1] = 1'b1;
          state_d    = StIdle;
        end
      end
      StLcmRd: begin
        // The ack cycle itself carries no LCM data.
        if (!ack_q) begin
          lcm_cap = 1'b1;
          if (iv_data_lcm[133:132] == TypTail) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      start_q <= 2'd0;
      ack_q   <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      wr_q    <= (|rd_en) | lcm_cap;
      if (rd_en[0])      data_q <= rd_word[0];
      else if (rd_en[1]) data_q <= rd_word[1];
      else if (lcm_cap)  data_q <= iv_data_lcm;
    end
  end

  assign o_data_lcm_ack = ack_q;
  assign o_data_wr      = wr_q;
  assign ov_data        = data_q;

endmodule

// File: tb/tb_lcm_output_arbiter.sv
// Directed bench for lcm_output_arbiter: FIFO path latency, round-robin,
// overflow rollback, missing tail, backpressure gating and async reset.
module tb_lcm_output_arbiter;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [133:0] iv_data_fem = '0;
  logic         i_data_fem_wr = 1'b0;
  logic [133:0] iv_data_fdm = '0;
  logic         i_data_fdm_wr = 1'b0;
  logic         i_data_lcm_req = 1'b0;
  logic         o_data_lcm_ack;
  logic [133:0] iv_data_lcm = '0;
  logic [6:0]   iv_fifo_usedw = 7'd0;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [15:0]  ov_fem_drop_cnt;
  logic [15:0]  ov_fdm_drop_cnt;

  lcm_output_arbiter #(.FIFO_AW(6), .USEDW_TH(7'd48)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .iv_data_fem    (iv_data_fem),
    .i_data_fem_wr  (i_data_fem_wr),
    .iv_data_fdm    (iv_data_fdm),
    .i_data_fdm_wr  (i_data_fdm_wr),
    .i_data_lcm_req (i_data_lcm_req),
    .o_data_lcm_ack (o_data_lcm_ack),
    .iv_data_lcm    (iv_data_lcm),
    .iv_fifo_usedw  (iv_fifo_usedw),
    .ov_data        (ov_data),
    .o_data_wr      (o_data_wr),
    .ov_fem_drop_cnt(ov_fem_drop_cnt),
    .ov_fdm_drop_cnt(ov_fdm_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [1:0] H = 2'b01, M = 2'b11, T = 2'b10;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int ack_cnt = 0;
  logic [133:0] out_q [$];
  int           out_cyc [$];

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_data_wr) begin
      out_q.push_back(ov_data);
      out_cyc.push_back(cyc);
    end
    if (o_data_lcm_ack) ack_cnt++;
  end

  function automatic logic [133:0] mk(input logic [1:0] t, input int id);
    return {t, 100'd0, 32'(id)};
  endfunction

  function automatic logic [133:0] got(input int i);
    return (i < out_q.size()) ? out_q[i] : 'x;
  endfunction

  function automatic int got_cyc(input int i);
    return (i < out_cyc.size()) ? out_cyc[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic word(input int src, input logic [1:0] t, input int id);
    if (src == 0) begin
      iv_data_fem = mk(t, id);
      i_data_fem_wr = 1'b1;
    end else if (src == 1) begin
      iv_data_fdm = mk(t, id);
      i_data_fdm_wr = 1'b1;
    end else begin
      iv_data_lcm = mk(t, id);
    end
    tick();
    i_data_fem_wr = 1'b0;
    i_data_fdm_wr = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && out_q.size() < n; i++) tick();
    repeat (4) tick();
  endtask

  task automatic wait_ack(output int t_ack);
    t_ack = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge i_clk);
      if (o_data_lcm_ack) begin
        t_ack = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    out_q.delete();
    out_cyc.delete();
  endtask

  int tc, t_ack, ack_base;
  logic [133:0] exp_w [$];

  initial begin
    #3;
    chk("rst_data", ov_data, '0);
    chk("rst_wr", {133'd0, o_data_wr}, '0);
    chk("rst_ack", {133'd0, o_data_lcm_ack}, '0);
    chk("rst_drops", {102'd0, ov_fem_drop_cnt, ov_fdm_drop_cnt}, '0);
    do_reset();

    // Single FEM packet
    word(0, H, 101); word(0, M, 102); word(0, M, 103);
    tc = cyc;
    word(0, T, 104);
    wait_words(4, 30);
    chk_int("t1_count", out_q.size(), 4);
    chk("t1_w0", got(0), mk(H, 101));
    chk("t1_w1", got(1), mk(M, 102));
    chk("t1_w2", got(2), mk(M, 103));
    chk("t1_w3", got(3), mk(T, 104));
    chk_int("t1_latency", got_cyc(0), tc + 3);
    chk_int("t1_back2back", got_cyc(3), tc + 6);

    // Round-robin across all three sources
    do_reset();
    iv_fifo_usedw = 7'd100;
    word(0, H, 201); word(0, T, 202); word(0, H, 203); word(0, T, 204);
    word(1, H, 301); word(1, T, 302); word(1, H, 303); word(1, T, 304);
    repeat (3) tick();
    chk_int("t2_gated", out_q.size(), 0);
    ack_base = ack_cnt;
    i_data_lcm_req = 1'b1;
    iv_fifo_usedw = 7'd0;
    wait_ack(t_ack);
    i_data_lcm_req = 1'b0;
    chk_int("t2_ack_seen", (t_ack >= 0) ? 1 : 0, 1);
    tick();
    word(2, H, 401); word(2, M, 402); word(2, T, 403);
    iv_data_lcm = '0;
    wait_words(11, 60);
    exp_w = '{mk(H, 201), mk(T, 202), mk(H, 301), mk(T, 302), mk(H, 401), mk(M, 402),
              mk(T, 403), mk(H, 203), mk(T, 204), mk(H, 303), mk(T, 304)};
    chk_int("t2_count", out_q.size(), 11);
    for (int i = 0; i < 11; i++) chk($sformatf("t2_w%0d", i), got(i), exp_w[i]);
    chk_int("t2_lcm_head_lat", got_cyc(4), t_ack + 2);
    chk_int("t2_ack_pulses", ack_cnt - ack_base, 1);

    // Overflow rollback
    do_reset();
    iv_fifo_usedw = 7'd100;
    word(0, H, 500);
    for (int i = 1; i < 69; i++) word(0, M, 500 + i);
    word(0, T, 569);
    repeat (2) tick();
    chk("t3_fem_drop", {118'd0, ov_fem_drop_cnt}, 134'd1);
    iv_fifo_usedw = 7'd0;
    repeat (10) tick();
    chk_int("t3_no_pkt", out_q.size(), 0);
    word(0, H, 601); word(0, M, 602); word(0, T, 603);
    wait_words(3, 30);
    chk_int("t3_count", out_q.size(), 3);
    chk("t3_w0", got(0), mk(H, 601));
    chk("t3_w1", got(1), mk(M, 602));
    chk("t3_w2", got(2), mk(T, 603));

    // Missing tail on FDM
    out_q.delete();
    out_cyc.delete();
    word(1, H, 701); word(1, M, 702);
    word(1, H, 711); word(1, M, 712); word(1, T, 713);
    wait_words(3, 30);
    chk("t4_fdm_drop", {118'd0, ov_fdm_drop_cnt}, 134'd1);
    chk("t4_fem_drop_kept", {118'd0, ov_fem_drop_cnt}, 134'd1);
    chk_int("t4_count", out_q.size(), 3);
    chk("t4_w0", got(0), mk(H, 711));
    chk("t4_w1", got(1), mk(M, 712));
    chk("t4_w2", got(2), mk(T, 713));

    // Backpressure gating
    out_q.delete();
    out_cyc.delete();
    iv_fifo_usedw = 7'd49;
    word(0, H, 801); word(0, M, 802); word(0, M, 803); word(0, T, 804);
    repeat (10) tick();
    chk_int("t5_blocked", out_q.size(), 0);
    iv_fifo_usedw = 7'd48;
    for (int i = 0; i < 20 && out_q.size() < 1; i++) tick();
    iv_fifo_usedw = 7'd60;
    wait_words(4, 20);
    chk_int("t5_count", out_q.size(), 4);
    chk("t5_w0", got(0), mk(H, 801));
    chk("t5_w3", got(3), mk(T, 804));
    chk_int("t5_contiguous", got_cyc(3) - got_cyc(0), 3);

    // Reset in the middle of an LCM transfer
    iv_fifo_usedw = 7'd0;
    i_data_lcm_req = 1'b1;
    wait_ack(t_ack);
    i_data_lcm_req = 1'b0;
    chk_int("t6_ack_seen", (t_ack >= 0) ? 1 : 0, 1);
    tick();
    word(2, H, 901);
    iv_data_lcm = mk(M, 902);
    chk("t6_head_out", ov_data, mk(H, 901));
    i_rst = 1'b1;
    #1;
    chk("t6_rst_data", ov_data, '0);
    chk("t6_rst_wr", {133'd0, o_data_wr}, '0);
    chk("t6_rst_ack", {133'd0, o_data_lcm_ack}, '0);
    chk("t6_rst_drops", {102'd0, ov_fem_drop_cnt, ov_fdm_drop_cnt}, '0);
    tick();
    iv_data_lcm = '0;
    i_rst = 1'b0;
    out_q.delete();
    out_cyc.delete();
    repeat (15) tick();
    chk_int("t6_quiet", out_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
